// File: rtl/paddle_rc_emulator_pkg.sv
// Shared state encoding, default constants and sizing helper for the paddle RC emulator.
package paddle_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_CHARGE  = 2'd1,
    CH_CHARGED = 2'd2
  } chan_state_e;

  localparam int         DEF_POS_W      = 8;
  localparam logic [7:0] DEF_POS_MIN    = 8'h10;
  localparam logic [7:0] DEF_POS_MAX    = 8'hF0;
  localparam logic [7:0] DEF_POS_INIT   = 8'h80;
  localparam int         DEF_STEP_DIV   = 65536;
  localparam int         DEF_CHG_OFFSET = 256;
  localparam int         DEF_CHG_SCALE  = 16;

  // Counter must hold the longest charge value itself (4096 at defaults needs 13 bits).
  function automatic int chg_cnt_width(input int offset, input int pos_max, input int scale);
    return $clog2(offset + pos_max * scale + 1);
  endfunction

endpackage

// File: rtl/paddle_rc_emulator_if.sv
// Player controls, chip discharge pins and the emulated charge/position outputs.
interface paddle_rc_emulator_if
  import paddle_pkg::*;
#(
  parameter int POS_W = DEF_POS_W
) ();

  logic [1:0]       i_up;
  logic [1:0]       i_down;
  logic             i_lp_dwn;
  logic             i_rp_dwn;
  logic             o_lp_in;
  logic             o_rp_in;
  logic [POS_W-1:0] o_lp_pos;
  logic [POS_W-1:0] o_rp_pos;

  modport master (
    output i_up, i_down, i_lp_dwn, i_rp_dwn,
    input  o_lp_in, o_rp_in, o_lp_pos, o_rp_pos
  );

  modport slave (
    input  i_up, i_down, i_lp_dwn, i_rp_dwn,
    output o_lp_in, o_rp_in, o_lp_pos, o_rp_pos
  );

endinterface

// File: rtl/paddle_rc_emulator_channel.sv
// One paddle: synchronizers, saturating position and the RC charge-time FSM.
module paddle_rc_channel
  import paddle_pkg::*;
#(
  parameter int               POS_W      = DEF_POS_W,
  parameter logic [POS_W-1:0] POS_MIN    = DEF_POS_MIN,
  parameter logic [POS_W-1:0] POS_MAX    = DEF_POS_MAX,
  parameter logic [POS_W-1:0] POS_INIT   = DEF_POS_INIT,
  parameter int               CHG_OFFSET = DEF_CHG_OFFSET,
  parameter int               CHG_SCALE  = DEF_CHG_SCALE
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             chip_rst_i,
  input  logic             step_tick_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic             dwn_i,
  output logic             in_o,
  output logic [POS_W-1:0] pos_o
);

  localparam int               CNT_W    = chg_cnt_width(CHG_OFFSET, int'(POS_MAX), CHG_SCALE);
  localparam logic [1:0]       S_IDLE    = CH_IDLE;
  localparam logic [1:0]       S_CHARGE  = CH_CHARGE;
  localparam logic [1:0]       S_CHARGED = CH_CHARGED;
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  logic [1:0]       dwn_sync_q;
  logic             dwn_dly_q;
  logic [1:0]       up_sync_q;
  logic [1:0]       down_sync_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_q, in_d;
  logic             dwn_fall_s;
  logic [CNT_W-1:0] chg_len_s;

  // Two-flop synchronizers plus one delay stage on dwn for edge detection.
  always_ff @(posedge clk50) begin
    if (reset) begin
      dwn_sync_q  <= 2'b11;
      dwn_dly_q   <= 1'b1;
      up_sync_q   <= 2'b00;
      down_sync_q <= 2'b00;
    end else begin
      dwn_sync_q  <= {dwn_sync_q[0], dwn_i};
      dwn_dly_q   <= dwn_sync_q[1];
      up_sync_q   <= {up_sync_q[0], up_i};
      down_sync_q <= {down_sync_q[0], down_i};
    end
  end

  // Load on the synchronized falling edge; release/abort look at the delayed copy so
  // output fall latency matches rise latency (3 edges from raw sample).
  assign dwn_fall_s = ~dwn_sync_q[1] & dwn_dly_q;
  assign chg_len_s  = CNT_W'(CHG_OFFSET) + (CNT_W'(pos_q) * CNT_W'(CHG_SCALE));

  // Saturating position step, applied only on the shared step tick.
  always_comb begin
    pos_d = pos_q;
    if (step_tick_i && up_sync_q[1] && !down_sync_q[1]) begin
      if (pos_q > POS_MIN) begin
        pos_d = pos_q - POS_ONE;
      end else begin
        pos_d = POS_MIN;
      end
    end else if (step_tick_i && down_sync_q[1] && !up_sync_q[1]) begin
      if (pos_q < POS_MAX) begin
        pos_d = pos_q + POS_ONE;
      end else begin
        pos_d = POS_MAX;
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Charge FSM next state; chip_rst overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = 1'b0;
    if (chip_rst_i) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
      in_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dwn_fall_s) begin
            state_d = S_CHARGE;
            cnt_d   = chg_len_s;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CHARGE: begin
          if (dwn_dly_q) begin
            state_d = S_IDLE;
          end else if (cnt_q == CNT_ZERO) begin
            state_d = S_CHARGED;
            in_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_CHARGED: begin
          if (dwn_dly_q) begin
            state_d = S_IDLE;
          end else begin
            in_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Position, FSM, counter and output registers.
  always_ff @(posedge clk50) begin
    if (reset) begin
      pos_q   <= POS_INIT;
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      in_q    <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
    end
  end

  assign in_o  = in_q;
  assign pos_o = pos_q;

endmodule

// File: rtl/paddle_rc_emulator.sv
// Emulates both AY-3-8500 paddle RC networks: shared step prescaler plus two channels.
module paddle_rc_emulator
  import paddle_pkg::*;
#(
  parameter int               POS_W      = DEF_POS_W,
  parameter logic [POS_W-1:0] POS_MIN    = DEF_POS_MIN,
  parameter logic [POS_W-1:0] POS_MAX    = DEF_POS_MAX,
  parameter logic [POS_W-1:0] POS_INIT   = DEF_POS_INIT,
  parameter int               STEP_DIV   = DEF_STEP_DIV,
  parameter int               CHG_OFFSET = DEF_CHG_OFFSET,
  parameter int               CHG_SCALE  = DEF_CHG_SCALE
) (
  input logic                 clk50,
  input logic                 reset,
  input logic                 chip_rst,
  paddle_rc_emulator_if.slave pad
);

  localparam int               PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             step_tick_s;
  logic             lp_in_s, rp_in_s;
  logic [POS_W-1:0] lp_pos_s, rp_pos_s;

  assign step_tick_s = (presc_q == PRE_LAST);

  // Free-running prescaler, wraps at STEP_DIV-1.
  always_comb begin
    if (step_tick_s) begin
      presc_d = {PRE_W{1'b0}};
    end else begin
      presc_d = presc_q + PRE_W'(1'b1);
    end
  end

  // Prescaler register; unaffected by chip_rst.
  always_ff @(posedge clk50) begin
    if (reset) begin
      presc_q <= {PRE_W{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end

  paddle_rc_channel #(
    .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
    .CHG_OFFSET(CHG_OFFSET), .CHG_SCALE(CHG_SCALE)
  ) u_left (
    .clk50(clk50), .reset(reset), .chip_rst_i(chip_rst), .step_tick_i(step_tick_s),
    .up_i(pad.i_up[0]), .down_i(pad.i_down[0]), .dwn_i(pad.i_lp_dwn),
    .in_o(lp_in_s), .pos_o(lp_pos_s)
  );

  paddle_rc_channel #(
    .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
    .CHG_OFFSET(CHG_OFFSET), .CHG_SCALE(CHG_SCALE)
  ) u_right (
    .clk50(clk50), .reset(reset), .chip_rst_i(chip_rst), .step_tick_i(step_tick_s),
    .up_i(pad.i_up[1]), .down_i(pad.i_down[1]), .dwn_i(pad.i_rp_dwn),
    .in_o(rp_in_s), .pos_o(rp_pos_s)
  );

  assign pad.o_lp_in  = lp_in_s;
  assign pad.o_rp_in  = rp_in_s;
  assign pad.o_lp_pos = lp_pos_s;
  assign pad.o_rp_pos = rp_pos_s;

endmodule

// File: tb/tb_paddle_rc_emulator.sv
// Directed bench for paddle_rc_emulator with an event-timed reference model and per-cycle compare.
module tb_paddle_rc_emulator;

  localparam int STEP_DIV_TB = 8;
  localparam int INF         = 32'h3fffffff;
  localparam int HN          = 65536;

  logic clk50 = 1'b0;
  logic reset;
  logic chip_rst;

  paddle_rc_emulator_if #(.POS_W(8)) pad ();

  paddle_rc_emulator #(.STEP_DIV(STEP_DIV_TB)) dut (
    .clk50(clk50), .reset(reset), .chip_rst(chip_rst), .pad(pad)
  );

  always #10 clk50 = ~clk50;

  int n_pass  = 0;
  int n_check = 0;
  bit chk_en  = 1'b0;

  // Reference model state: edge count since reset and per-channel event times.
  int         e;
  logic [1:0] up_hist [HN];
  logic [1:0] dn_hist [HN];
  int         mpos    [2];
  int         load_at [2];
  int         r_edge  [2];
  int         f_edge  [2];
  bit         prev_raw[2];
  bit         mout    [2];

  task automatic check(input string name, input int act, input int exp);
    n_check++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  // Output is high on [N+3+L, M+3) where N/M are the edges raw dwn was first seen low/high.
  task automatic model_step();
    logic raw, u, d;
    if (reset) begin
      e = 0;
      for (int c = 0; c < 2; c++) begin
        mpos[c] = 128; load_at[c] = INF; r_edge[c] = INF; f_edge[c] = INF;
        prev_raw[c] = 1'b1; mout[c] = 1'b0;
      end
    end else begin
      e = e + 1;
      up_hist[e % HN] = pad.i_up;
      dn_hist[e % HN] = pad.i_down;
      for (int c = 0; c < 2; c++) begin
        raw = (c == 0) ? pad.i_lp_dwn : pad.i_rp_dwn;
        if (chip_rst) begin
          r_edge[c] = INF;
          if (load_at[c] == e) load_at[c] = INF;
        end else if (load_at[c] == e) begin
          r_edge[c]  = e + 1 + 256 + mpos[c] * 16;
          f_edge[c]  = INF;
          load_at[c] = INF;
        end
        if ((e % STEP_DIV_TB) == 0 && e > 2) begin
          u = up_hist[(e - 2) % HN][c];
          d = dn_hist[(e - 2) % HN][c];
          if (u && !d) mpos[c] = (mpos[c] - 1 < 16) ? 16 : mpos[c] - 1;
          else if (d && !u) mpos[c] = (mpos[c] + 1 > 240) ? 240 : mpos[c] + 1;
        end
        if (!raw && prev_raw[c]) load_at[c] = e + 2;
        if (raw && !prev_raw[c]) f_edge[c] = e + 3;
        prev_raw[c] = raw;
        mout[c] = (e >= r_edge[c]) && (e < f_edge[c]);
      end
    end
  endtask

  initial forever begin
    @(posedge clk50);
    model_step();
  end

  initial forever begin
    @(negedge clk50);
    if (chk_en) begin
      check("lp_in",  int'(pad.o_lp_in),  int'(mout[0]));
      check("rp_in",  int'(pad.o_rp_in),  int'(mout[1]));
      check("lp_pos", int'(pad.o_lp_pos), mpos[0]);
      check("rp_pos", int'(pad.o_rp_pos), mpos[1]);
    end
  end

  task automatic wait_level(input int side, input logic lvl, input int budget, output int edge_o);
    bit done;
    done   = 1'b0;
    edge_o = -1;
    for (int k = 0; k < budget && !done; k++) begin
      if (((side == 0) ? pad.o_lp_in : pad.o_rp_in) == lvl) begin
        edge_o = e;
        done   = 1'b1;
      end else begin
        @(negedge clk50);
      end
    end
  endtask

  initial begin
    int n0, m0, t, tl, tr;
    bit hi;
    reset = 1'b1; chip_rst = 1'b0;
    pad.i_up = 2'b00; pad.i_down = 2'b00; pad.i_lp_dwn = 1'b1; pad.i_rp_dwn = 1'b1;
    repeat (3) @(negedge clk50);
    chk_en = 1'b1;
    check("rst_lp_pos", int'(pad.o_lp_pos), 128);
    check("rst_rp_pos", int'(pad.o_rp_pos), 128);
    check("rst_lp_in",  int'(pad.o_lp_in),  0);
    check("rst_rp_in",  int'(pad.o_rp_in),  0);
    reset = 1'b0;
    repeat (10) @(negedge clk50);

    // Centre position: 256 + 128*16 = 2304
    pad.i_lp_dwn = 1'b0; n0 = e + 1;
    wait_level(0, 1'b1, 5000, t);
    check("lat_center", t - n0, 2307);
    pad.i_lp_dwn = 1'b1; m0 = e + 1;
    wait_level(0, 1'b0, 20, t);
    check("fall_lat", t - m0, 3);
    repeat (20) @(negedge clk50);

    // Abort after 1000 cycles, then a full restart
    pad.i_lp_dwn = 1'b0;
    repeat (1000) @(negedge clk50);
    pad.i_lp_dwn = 1'b1;
    hi = 1'b0;
    repeat (2500) begin
      @(negedge clk50);
      if (pad.o_lp_in) hi = 1'b1;
    end
    check("abort_no_rise", int'(hi), 0);
    pad.i_lp_dwn = 1'b0; n0 = e + 1;
    wait_level(0, 1'b1, 5000, t);
    check("lat_restart", t - n0, 2307);
    pad.i_lp_dwn = 1'b1;
    repeat (20) @(negedge clk50);

    // Left to the top stop
    pad.i_up = 2'b01;
    repeat (200 * STEP_DIV_TB) @(negedge clk50);
    check("lp_sat_min", int'(pad.o_lp_pos), 16);
    check("rp_unmoved", int'(pad.o_rp_pos), 128);
    pad.i_up = 2'b00;
    repeat (10) @(negedge clk50);
    pad.i_lp_dwn = 1'b0; n0 = e + 1;
    wait_level(0, 1'b1, 5000, t);
    check("lat_min", t - n0, 515);
    pad.i_lp_dwn = 1'b1;
    repeat (20) @(negedge clk50);

    // Right to the bottom stop, then both directions together
    pad.i_down = 2'b10;
    repeat (200 * STEP_DIV_TB) @(negedge clk50);
    check("rp_sat_max", int'(pad.o_rp_pos), 240);
    pad.i_up = 2'b10;
    repeat (20 * STEP_DIV_TB) @(negedge clk50);
    check("rp_both_hold", int'(pad.o_rp_pos), 240);
    pad.i_up = 2'b00; pad.i_down = 2'b00;
    repeat (10) @(negedge clk50);
    pad.i_rp_dwn = 1'b0; n0 = e + 1;
    wait_level(1, 1'b1, 6000, t);
    check("lat_max", t - n0, 4099);
    pad.i_rp_dwn = 1'b1;
    repeat (20) @(negedge clk50);

    // Both channels at once
    pad.i_lp_dwn = 1'b0; pad.i_rp_dwn = 1'b0; n0 = e + 1;
    wait_level(0, 1'b1, 6000, tl);
    wait_level(1, 1'b1, 6000, tr);
    check("both_lp_lat", tl - n0, 515);
    check("both_gap", tr - tl, 3584);
    pad.i_lp_dwn = 1'b1; pad.i_rp_dwn = 1'b1; m0 = e + 1;
    wait_level(0, 1'b0, 20, tl);
    wait_level(1, 1'b0, 20, tr);
    check("both_lp_fall", tl - m0, 3);
    check("both_rp_fall", tr - m0, 3);
    repeat (20) @(negedge clk50);

    // chip_rst while charged
    pad.i_lp_dwn = 1'b0;
    wait_level(0, 1'b1, 5000, t);
    check("chg_before_crst", int'(pad.o_lp_in), 1);
    chip_rst = 1'b1;
    @(negedge clk50);
    chip_rst = 1'b0;
    check("crst_in", int'(pad.o_lp_in), 0);
    check("crst_pos", int'(pad.o_lp_pos), 16);
    repeat (10) @(negedge clk50);
    check("crst_stays_low", int'(pad.o_lp_in), 0);
    pad.i_lp_dwn = 1'b1;
    repeat (20) @(negedge clk50);

    // reset mid-charge
    pad.i_lp_dwn = 1'b0;
    repeat (100) @(negedge clk50);
    reset = 1'b1; pad.i_lp_dwn = 1'b1;
    @(negedge clk50);
    reset = 1'b0;
    check("mid_rst_lp_pos", int'(pad.o_lp_pos), 128);
    check("mid_rst_rp_pos", int'(pad.o_rp_pos), 128);
    check("mid_rst_lp_in",  int'(pad.o_lp_in),  0);
    repeat (30) @(negedge clk50);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_check);
    $fatal(1);
  end

endmodule
